// File: rtl/aes_dec_pkg.sv
// Shared definitions for the byte-serial AES-128 decryption state unit.
// GF(2^8) reduction constant, xtime helper and the InvShiftRows source table.
package aes_dec_pkg;

    localparam logic [7:0] AES_POLY_RED = 8'h1B;
    localparam int         STATE_BYTES  = 16;

    typedef enum logic [1:0] {
        UPD_HOLD,
        UPD_SHIFT,
        UPD_IMC,
        UPD_ISR
    } upd_mode_e;

    // Source byte index for each destination byte of InvShiftRows (column-major S[4c+r]).
    localparam logic [3:0] ISR_SRC [STATE_BYTES] = '{
        4'd0,  4'd13, 4'd10, 4'd7,
        4'd4,  4'd1,  4'd14, 4'd11,
        4'd8,  4'd5,  4'd2,  4'd15,
        4'd12, 4'd9,  4'd6,  4'd3
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY_RED : 8'h00);
    endfunction

endpackage

// File: rtl/inv_mix_column.sv
// Combinational InvMixColumns on one 4-byte column: rows of the [0e 0b 0d 09] circulant.
// Built from an xtime chain so only XORs and conditional reductions are needed.
module inv_mix_column
    import aes_dec_pkg::*;
(
    input  logic [3:0][7:0] col_in,
    output logic [3:0][7:0] col_out
);

    logic [7:0] x2  [4];
    logic [7:0] x4  [4];
    logic [7:0] x8  [4];
    logic [7:0] m09 [4];
    logic [7:0] m0b [4];
    logic [7:0] m0d [4];
    logic [7:0] m0e [4];

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            x2[r]  = xtime(col_in[r]);
            x4[r]  = xtime(x2[r]);
            x8[r]  = xtime(x4[r]);
            m09[r] = x8[r] ^ col_in[r];
            m0b[r] = x8[r] ^ x2[r] ^ col_in[r];
            m0d[r] = x8[r] ^ x4[r] ^ col_in[r];
            m0e[r] = x8[r] ^ x4[r] ^ x2[r];
        end
    end

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            col_out[r] = m0e[r] ^ m0b[2'(r + 1)] ^ m0d[2'(r + 2)] ^ m09[2'(r + 3)];
        end
    end

endmodule

// File: rtl/inv_data_registers_unit.sv
// Byte-serial AES-128 decryption state register file: 16-byte shift chain with in-place
// InvShiftRows, column-at-a-time InvMixColumns and a one-byte guard register.
module inv_data_registers_unit
    import aes_dec_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       doSG,
    input  logic       doCG,
    input  logic       doIMC,
    input  logic       doISR,
    input  logic [7:0] stateIn,
    output logic [7:0] stateOut,
    output logic [7:0] guards,
    output logic [7:0] plain
);

    logic [7:0]      state_q [STATE_BYTES];
    logic [7:0]      state_d [STATE_BYTES];
    logic [7:0]      guard_q;
    logic [7:0]      guard_d;
    logic [3:0][7:0] imc_in;
    logic [3:0][7:0] imc_out;
    upd_mode_e       mode;

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            imc_in[r] = state_q[r];
        end
    end

    inv_mix_column u_imc (
        .col_in  (imc_in),
        .col_out (imc_out)
    );

    // Permutation wins over the column step; both win over the plain shift.
    always_comb begin
        if (!en) begin
            mode = UPD_HOLD;
        end else if (doISR) begin
            mode = UPD_ISR;
        end else if (doIMC) begin
            mode = UPD_IMC;
        end else begin
            mode = UPD_SHIFT;
        end
    end

    always_comb begin
        state_d = state_q;
        case (mode)
            UPD_ISR: begin
                for (int i = 0; i < STATE_BYTES; i++) begin
                    state_d[i] = state_q[ISR_SRC[i]];
                end
            end
            UPD_SHIFT, UPD_IMC: begin
                for (int i = 0; i < STATE_BYTES - 1; i++) begin
                    state_d[i] = state_q[i + 1];
                end
                state_d[STATE_BYTES - 1] = stateIn;
                // m0 leaves on stateOut; m1..m3 stay at the head of the chain.
                if (mode == UPD_IMC) begin
                    state_d[0] = imc_out[1];
                    state_d[1] = imc_out[2];
                    state_d[2] = imc_out[3];
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        guard_d = (en && doSG) ? state_q[0] : guard_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STATE_BYTES; i++) begin
                state_q[i] <= 8'h00;
            end
            guard_q <= 8'h00;
        end else begin
            for (int i = 0; i < STATE_BYTES; i++) begin
                state_q[i] <= state_d[i];
            end
            guard_q <= guard_d;
        end
    end

    always_comb begin
        stateOut = (mode == UPD_IMC) ? imc_out[0] : state_q[0];
        guards   = doCG ? guard_q : state_q[1];
        plain    = state_q[0];
    end

endmodule

// File: tb/tb_inv_data_registers_unit.sv
// Scoreboard bench for inv_data_registers_unit: stimulus pushes expected outputs into a queue,
// a negedge monitor pops and compares; a GF(2^8) reference model runs a full AES-128 decrypt.
module tb_inv_data_registers_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       doSG = 1'b0;
    logic       doCG = 1'b0;
    logic       doIMC = 1'b0;
    logic       doISR = 1'b0;
    logic [7:0] stateIn = 8'h00;
    logic [7:0] stateOut;
    logic [7:0] guards;
    logic [7:0] plain;

    inv_data_registers_unit dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .doSG     (doSG),
        .doCG     (doCG),
        .doIMC    (doIMC),
        .doISR    (doISR),
        .stateIn  (stateIn),
        .stateOut (stateOut),
        .guards   (guards),
        .plain    (plain)
    );

    always #5 clk = ~clk;

    int cycleNum = 0;
    always @(posedge clk) cycleNum <= cycleNum + 1;

    int         expCyc  [$];
    int         expSel  [$];
    logic [7:0] expVal  [$];
    string      expName [$];
    int         checksDone   = 0;
    int         checksPassed = 0;

    logic [7:0] refS [16];
    logic [7:0] refG;
    logic [7:0] invSboxTab [256];
    logic [7:0] rk [11][16];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h00;
        if (a != 8'h00) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, a);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] refMixRow(input logic [7:0] col [4], input int row);
        logic [7:0] coef [4];
        logic [7:0] acc;
        coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        acc  = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j - row + 4) % 4], col[j]);
        return acc;
    endfunction

    function automatic logic [7:0] refStateOut(input bit e, input bit imc, input bit isr);
        logic [7:0] col [4];
        col = '{refS[0], refS[1], refS[2], refS[3]};
        return (e && imc && !isr) ? refMixRow(col, 0) : refS[0];
    endfunction

    task automatic refUpdate(input bit e, input bit sg, input bit imc, input bit isr,
                             input logic [7:0] din);
        logic [7:0] old [16];
        logic [7:0] col [4];
        old = refS;
        col = '{old[0], old[1], old[2], old[3]};
        if (e) begin
            if (sg) refG = old[0];
            if (isr) begin
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        refS[4 * c + r] = old[4 * ((c - r + 4) % 4) + r];
            end else begin
                for (int i = 0; i < 15; i++) refS[i] = old[i + 1];
                refS[15] = din;
                if (imc) for (int r = 0; r < 3; r++) refS[r] = refMixRow(col, r + 1);
            end
        end
    endtask

    task automatic pushExp(input int sel, input logic [7:0] v, input string nm);
        expCyc.push_back(cycleNum);
        expSel.push_back(sel);
        expVal.push_back(v);
        expName.push_back(nm);
    endtask

    task automatic checkOutput(input int cyc, input int sel, input logic [7:0] exp,
                               input string nm);
        logic [7:0] act;
        act = (sel == 0) ? stateOut : (sel == 1) ? guards : plain;
        checksDone++;
        if (cyc != cycleNum)
            $display("[TB] FAIL %s: never sampled in cycle %0d (now %0d), required %02h",
                     nm, cyc, cycleNum, exp);
        else if (act === exp)
            checksPassed++;
        else
            $display("[TB] FAIL %s cycle %0d: got %02h, required %02h", nm, cyc, act, exp);
    endtask

    always @(negedge clk) begin
        while (expCyc.size() > 0 && expCyc[0] <= cycleNum) begin
            checkOutput(expCyc.pop_front(), expSel.pop_front(), expVal.pop_front(),
                        expName.pop_front());
        end
    end

    task automatic applyStimulus(input bit e, input bit sg, input bit cg, input bit imc,
                                 input bit isr, input logic [7:0] din);
        @(posedge clk);
        #1;
        en      = e;
        doSG    = sg;
        doCG    = cg;
        doIMC   = imc;
        doISR   = isr;
        stateIn = din;
        pushExp(0, refStateOut(e, imc, isr), "stateOut");
        pushExp(1, cg ? refG : refS[1], "guards");
        pushExp(2, refS[0], "plain");
        refUpdate(e, sg, imc, isr, din);
    endtask

    task automatic applyReset();
        @(posedge clk);
        #1;
        rst   = 1'b1;
        en    = 1'b0;
        doSG  = 1'b0;
        doCG  = 1'b0;
        doIMC = 1'b0;
        doISR = 1'b0;
        for (int i = 0; i < 16; i++) refS[i] = 8'h00;
        refG = 8'h00;
        pushExp(0, 8'h00, "rstStateOut");
        pushExp(1, 8'h00, "rstGuards");
        pushExp(2, 8'h00, "rstPlain");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic loadBytes(input logic [7:0] b [16]);
        for (int i = 0; i < 16; i++) applyStimulus(1, 0, 0, 0, 0, b[i]);
    endtask

    task automatic expandKey(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            for (int i = 0; i < 16; i++)
                rk[r][i] = w[4 * r + i / 4][31 - 8 * (i % 4) -: 8];
    endtask

    initial begin
        logic [7:0]   bytes [16];
        logic [7:0]   isrExp [16];
        logic [31:0]  vecIn [4];
        logic [31:0]  vecOut [4];
        logic [7:0]   held;
        logic [127:0] ct;

        isrExp = '{8'h00, 8'h0d, 8'h0a, 8'h07, 8'h04, 8'h01, 8'h0e, 8'h0b,
                   8'h08, 8'h05, 8'h02, 8'h0f, 8'h0c, 8'h09, 8'h06, 8'h03};
        vecIn  = '{32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6};
        vecOut = '{32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6};
        for (int a = 0; a < 256; a++) invSboxTab[sbox(8'(a))] = 8'(a);

        applyReset();

        // Reset in the middle of a load discards everything loaded so far.
        for (int i = 0; i < 7; i++) applyStimulus(1, 0, 0, 0, 0, 8'($urandom));
        applyReset();
        for (int i = 0; i < 16; i++) bytes[i] = 8'(i);
        loadBytes(bytes);

        applyStimulus(1, 0, 0, 0, 1, 8'($urandom));
        pushExp(2, 8'h00, "reloadS0");
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1, 0, 0, 0, 0, 8'($urandom));
            pushExp(0, isrExp[k], "isrStream");
        end

        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 16; i++) bytes[i] = (i < 4) ? vecIn[v][31 - 8 * i -: 8] : 8'($urandom);
            loadBytes(bytes);
            applyStimulus(1, 0, 0, 1, 0, refStateOut(1, 1, 0));
            pushExp(0, vecOut[v][31:24], "imcM0");
            for (int k = 1; k < 4; k++) begin
                applyStimulus(1, 0, 0, 0, 0, refS[0]);
                pushExp(0, vecOut[v][31 - 8 * k -: 8], "imcNext");
            end
        end

        for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom);
        bytes[0] = 8'h5a;
        bytes[1] = 8'h3c;
        loadBytes(bytes);
        applyStimulus(1, 1, 0, 0, 0, 8'($urandom));
        pushExp(1, 8'h3c, "guardsS1");
        applyStimulus(0, 0, 1, 0, 0, 8'($urandom));
        pushExp(1, 8'h5a, "guardsG");
        applyStimulus(0, 0, 0, 0, 0, 8'($urandom));

        held = refS[0];
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 0, 0, 1, 8'($urandom));
            pushExp(0, held, "enHold");
        end
        held = refS[0];
        applyStimulus(1, 0, 0, 1, 1, 8'($urandom));
        pushExp(0, held, "isrOverImc");
        for (int k = 0; k < 16; k++) applyStimulus(1, 0, 0, 0, 0, 8'($urandom));

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 63) == 0) applyReset();
            else applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0,
                               1'($urandom), $urandom_range(0, 3) == 0,
                               $urandom_range(0, 7) == 0, 8'($urandom));
        end

        // Full decrypt of the FIPS-197 C.1 ciphertext driven by a model controller.
        expandKey(128'h000102030405060708090a0b0c0d0e0f);
        ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        for (int i = 0; i < 16; i++) applyStimulus(1, 0, 0, 0, 0, ct[127 - 8 * i -: 8] ^ rk[10][i]);
        for (int r = 9; r >= 0; r--) begin
            applyStimulus(1, 0, 0, 0, 1, 8'h00);
            for (int i = 0; i < 16; i++) applyStimulus(1, 0, 0, 0, 0, invSboxTab[refS[0]] ^ rk[r][i]);
            if (r > 0) begin
                for (int c = 0; c < 4; c++) begin
                    applyStimulus(1, 0, 0, 1, 0, refStateOut(1, 1, 0));
                    for (int k = 0; k < 3; k++) applyStimulus(1, 0, 0, 0, 0, refS[0]);
                end
            end
        end
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 8'h00);
            pushExp(2, 8'(i * 17), "plainStream");
        end

        repeat (3) @(posedge clk);
        #1;
        while (expCyc.size() > 0) begin
            checkOutput(expCyc.pop_front(), expSel.pop_front(), expVal.pop_front(),
                        expName.pop_front());
        end
        $display("%0d/%0d checks passed", checksPassed, checksDone);
        $finish;
    end

endmodule
